// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares one data-memory port between a load FU and a store FU.
// One transaction is in flight at a time:
//   IDLE -> REQ (command driven, re-driven while memory rejects it)
//   REQ  -> WAIT (load accepted; wait for the data tag)
//   REQ/WAIT -> DRAIN (load squashed after memory accepted it; swallow data)
// Store transactions finish with an st_ack pulse when memory accepts them.
// Load transactions finish with an ld_ack pulse when the data tag returns.
//
// Handshake: a requester raises i_*_req with its packet stable and keeps it
// there until it sees its one-cycle o_*_ack; the arbiter samples requests in
// IDLE only, and the granted command appears on the bus the following cycle.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration.
// Otherwise loads have fixed priority over stores.
//
// Ports:
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_ld_req, i_ld_addr, i_ld_size   load FU request and packet
//   i_st_req, i_st_addr, i_st_data,
//   i_st_size                        store FU request and packet
//   i_squash                         pipeline flush (aborts loads only)
//   i_dmem2proc_response             tag of accepted command, 0 = rejected
//   i_dmem2proc_data/_tag            returning load data and its tag
//   o_proc2dmem_command/addr/data/size  memory command bus
//   o_ld_ack, o_ld_data              load completion pulse and data
//   o_st_ack                         store acceptance pulse
//   o_busy                           high whenever not IDLE
//   o_state                          current FSM state (debug)
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ld_req,
   input  logic [XLEN-1:0]  i_ld_addr,
   input  logic [1:0]       i_ld_size,
   input  logic             i_st_req,
   input  logic [XLEN-1:0]  i_st_addr,
   input  logic [XLEN-1:0]  i_st_data,
   input  logic [1:0]       i_st_size,
   input  logic             i_squash,
   input  logic [TAG_W-1:0] i_dmem2proc_response,
   input  logic [XLEN-1:0]  i_dmem2proc_data,
   input  logic [TAG_W-1:0] i_dmem2proc_tag,
   output logic [1:0]       o_proc2dmem_command,
   output logic [XLEN-1:0]  o_proc2dmem_addr,
   output logic [XLEN-1:0]  o_proc2dmem_data,
   output logic [1:0]       o_proc2dmem_size,
   output logic             o_ld_ack,
   output logic [XLEN-1:0]  o_ld_data,
   output logic             o_st_ack,
   output logic             o_busy,
   output logic [1:0]       o_state
);

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [1:0]       r_cmd;
   logic [XLEN-1:0]  r_addr;
   logic [XLEN-1:0]  r_data;
   logic [1:0]       r_size;
   logic             r_is_load;
   logic [TAG_W-1:0] r_tag;
   logic [XLEN-1:0]  r_ld_data;
   logic             r_ld_ack;
   logic             r_st_ack;

   logic w_pick_ld;
   logic w_pick_st;
   logic w_grant_ld;
   logic w_grant_st;
   logic w_clear_cmd;
   logic w_save_tag;
   logic w_capture;
   logic w_ld_ack_nxt;
   logic w_st_ack_nxt;
   logic w_tag_hit;
   logic w_resp_ok;

   assign w_resp_ok = (i_dmem2proc_response != '0);
   // Saved tag is never 0 while a load is outstanding, so a 0 tag never hits.
   assign w_tag_hit = (i_dmem2proc_tag == r_tag) && (r_tag != '0);

`ifdef MEM_ARB_RR_EN
   // r_rr_st_pri: 1 when the store side wins a tie (load was granted last).
   logic r_rr_st_pri;

   assign w_pick_ld = i_ld_req && (!i_st_req || !r_rr_st_pri);
   assign w_pick_st = i_st_req && !w_pick_ld;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_st_pri <= 1'b0;
      end else if (w_grant_ld) begin
         r_rr_st_pri <= 1'b1;
      end else if (w_grant_st) begin
         r_rr_st_pri <= 1'b0;
      end
   end
`else
   assign w_pick_ld = i_ld_req;
   assign w_pick_st = i_st_req && !i_ld_req;
`endif

   // Next-state and control decode.
   always_comb begin
      w_next_state = r_state;
      w_grant_ld   = 1'b0;
      w_grant_st   = 1'b0;
      w_clear_cmd  = 1'b0;
      w_save_tag   = 1'b0;
      w_capture    = 1'b0;
      w_ld_ack_nxt = 1'b0;
      w_st_ack_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Squash is meaningless here: nothing is in flight.
            if (w_pick_ld) begin
               w_grant_ld   = 1'b1;
               w_next_state = S_REQ;
            end else if (w_pick_st) begin
               w_grant_st   = 1'b1;
               w_next_state = S_REQ;
            end
         end
         S_REQ: begin
            if (r_is_load && i_squash) begin
               w_clear_cmd = 1'b1;
               // Memory may have accepted in the squash cycle; its data
               // must still be swallowed so the tag is not left dangling.
               if (w_resp_ok) begin
                  w_save_tag   = 1'b1;
                  w_next_state = S_DRAIN;
               end else begin
                  w_next_state = S_IDLE;
               end
            end else if (w_resp_ok) begin
               w_clear_cmd = 1'b1;
               if (r_is_load) begin
                  w_save_tag   = 1'b1;
                  w_next_state = S_WAIT;
               end else begin
                  w_st_ack_nxt = 1'b1;
                  w_next_state = S_IDLE;
               end
            end
         end
         S_WAIT: begin
            if (i_squash) begin
               // Squash coinciding with the data: transaction is over, no ack.
               w_next_state = w_tag_hit ? S_IDLE : S_DRAIN;
            end else if (w_tag_hit) begin
               w_capture    = 1'b1;
               w_ld_ack_nxt = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (w_tag_hit) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cmd     <= BUS_NONE;
         r_addr    <= '0;
         r_data    <= '0;
         r_size    <= '0;
         r_is_load <= 1'b0;
         r_tag     <= '0;
         r_ld_data <= '0;
         r_ld_ack  <= 1'b0;
         r_st_ack  <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_ld_ack <= w_ld_ack_nxt;
         r_st_ack <= w_st_ack_nxt;
         if (w_grant_ld) begin
            r_cmd     <= BUS_LOAD;
            r_addr    <= i_ld_addr;
            r_data    <= '0;
            r_size    <= i_ld_size;
            r_is_load <= 1'b1;
         end else if (w_grant_st) begin
            r_cmd     <= BUS_STORE;
            r_addr    <= i_st_addr;
            r_data    <= i_st_data;
            r_size    <= i_st_size;
            r_is_load <= 1'b0;
         end else if (w_clear_cmd) begin
            r_cmd <= BUS_NONE;
         end
         if (w_save_tag) begin
            r_tag <= i_dmem2proc_response;
         end
         if (w_capture) begin
            r_ld_data <= i_dmem2proc_data;
         end
      end
   end

   // A squashed load leaves the bus in the very cycle squash is seen.
   assign o_proc2dmem_command = (r_state == S_REQ && r_is_load && i_squash) ? BUS_NONE : r_cmd;
   assign o_proc2dmem_addr    = r_addr;
   assign o_proc2dmem_data    = r_data;
   assign o_proc2dmem_size    = r_size;
   assign o_ld_ack            = r_ld_ack;
   assign o_ld_data           = r_ld_data;
   assign o_st_ack            = r_st_ack;
   assign o_busy              = (r_state != S_IDLE);
   assign o_state             = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized FU/memory traffic. A transaction-level model (who owns the bus,
// whether memory accepted, which tag is outstanding) predicts every output
// each cycle. Honors MEM_ARB_RR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
   localparam int TAG_W = 4;
   localparam int XLEN  = 32;
   localparam logic [1:0] C_NONE  = 2'd0;
   localparam logic [1:0] C_LOAD  = 2'd1;
   localparam logic [1:0] C_STORE = 2'd2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ld_req, st_req, squash;
   logic [XLEN-1:0]  ld_addr, st_addr, st_data, ddata;
   logic [1:0]       ld_size, st_size;
   logic [TAG_W-1:0] resp, dtag;
   logic [1:0]       cmd, psize, dut_state;
   logic [XLEN-1:0]  paddr, pdata, ld_data;
   logic             ld_ack, st_ack, busy;

   always #5 clk = ~clk;

   mem_arbiter #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ld_req(ld_req), .i_ld_addr(ld_addr), .i_ld_size(ld_size),
      .i_st_req(st_req), .i_st_addr(st_addr), .i_st_data(st_data), .i_st_size(st_size),
      .i_squash(squash),
      .i_dmem2proc_response(resp), .i_dmem2proc_data(ddata), .i_dmem2proc_tag(dtag),
      .o_proc2dmem_command(cmd), .o_proc2dmem_addr(paddr), .o_proc2dmem_data(pdata),
      .o_proc2dmem_size(psize), .o_ld_ack(ld_ack), .o_ld_data(ld_data),
      .o_st_ack(st_ack), .o_busy(busy), .o_state(dut_state)
   );

   int checks;
   int errors;

   // Transaction-level model: owner 0 = none, 1 = load, 2 = store.
   int               m_owner;
   bit               m_accepted, m_drain, m_store_turn, m_ld_ack, m_st_ack;
   logic [TAG_W-1:0] m_tag;
   logic [XLEN-1:0]  m_addr, m_data, m_ld_data;
   logic [1:0]       m_size;

   // Bench memory: at most one outstanding load tag.
   bit               pend_valid;
   logic [TAG_W-1:0] pend_tag;
   int               pend_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_accepted = 0; m_drain = 0; m_store_turn = 0;
      m_ld_ack = 0; m_st_ack = 0; m_tag = '0;
      m_addr = '0; m_data = '0; m_size = '0; m_ld_data = '0;
   endtask

   task automatic model_update();
      bit take_ld, take_st, hit;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_ld_ack = 0;
      m_st_ack = 0;
      if (m_owner == 0) begin
`ifdef MEM_ARB_RR_EN
         take_ld = ld_req && (!st_req || !m_store_turn);
`else
         take_ld = ld_req;
`endif
         take_st = st_req && !take_ld;
         if (take_ld) begin
            m_owner = 1; m_addr = ld_addr; m_data = '0; m_size = ld_size;
            m_accepted = 0; m_drain = 0; m_store_turn = 1;
         end else if (take_st) begin
            m_owner = 2; m_addr = st_addr; m_data = st_data; m_size = st_size;
            m_accepted = 0; m_drain = 0; m_store_turn = 0;
         end
      end else if (!m_accepted) begin
         if (m_owner == 1 && squash) begin
            if (resp != 0) begin m_accepted = 1; m_tag = resp; m_drain = 1; end
            else m_owner = 0;
         end else if (resp != 0) begin
            if (m_owner == 2) begin m_st_ack = 1; m_owner = 0; end
            else begin m_accepted = 1; m_tag = resp; m_drain = 0; end
         end
      end else begin
         hit = (dtag == m_tag);
         if (squash) m_drain = 1;
         if (hit) begin
            if (!m_drain) begin m_ld_data = ddata; m_ld_ack = 1; end
            m_owner = 0;
         end
      end
   endtask

   task automatic compare();
      logic [1:0] exp_cmd;
      exp_cmd = C_NONE;
      if (m_owner != 0 && !m_accepted && !(m_owner == 1 && squash))
         exp_cmd = (m_owner == 1) ? C_LOAD : C_STORE;
      check("cmd", 32'(cmd), 32'(exp_cmd));
      check("addr", paddr, m_addr);
      check("wdata", pdata, m_data);
      check("size", 32'(psize), 32'(m_size));
      check("ld_ack", 32'(ld_ack), 32'(m_ld_ack));
      check("ld_data", ld_data, m_ld_data);
      check("st_ack", 32'(st_ack), 32'(m_st_ack));
      check("busy", 32'(busy), 32'(m_owner != 0));
      check("ack_excl", 32'(ld_ack & st_ack), 32'd0);
   endtask

   // One clock: model steps on the rising edge, outputs compared on the
   // falling edge, then the caller drives new inputs 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
      #1;
   endtask

   task automatic clear_inputs();
      ld_req = 0; st_req = 0; squash = 0;
      ld_addr = '0; st_addr = '0; st_data = '0; ld_size = '0; st_size = '0;
      resp = '0; ddata = '0; dtag = '0;
   endtask

   task automatic mem_drive();
      logic [TAG_W-1:0] t;
      ddata = $urandom;
      dtag = '0;
      if (pend_valid) begin
         if (pend_cnt == 0) begin
            dtag = pend_tag;
            pend_valid = 0;
         end else begin
            pend_cnt--;
            if ($urandom_range(0, 3) == 0) begin
               t = TAG_W'($urandom_range(1, 15));
               while (t == pend_tag) t = TAG_W'($urandom_range(1, 15));
               dtag = t;
            end
         end
      end else if ($urandom_range(0, 3) == 0) begin
         dtag = TAG_W'($urandom_range(1, 15));
      end
      resp = '0;
      if (cmd != C_NONE && $urandom_range(0, 2) == 0) begin
         resp = TAG_W'($urandom_range(1, 15));
         if (cmd == C_LOAD) begin
            pend_valid = 1;
            pend_tag = resp;
            pend_cnt = $urandom_range(1, 6);
         end
      end
   endtask

   task automatic fu_drive();
      if (ld_req && ld_ack) ld_req = 0;
      else if (!ld_req && $urandom_range(0, 3) == 0) begin
         ld_req = 1; ld_addr = $urandom; ld_size = 2'($urandom_range(0, 3));
      end
      if (st_req && st_ack) st_req = 0;
      else if (!st_req && $urandom_range(0, 3) == 0) begin
         st_req = 1; st_addr = $urandom; st_data = $urandom; st_size = 2'($urandom_range(0, 3));
      end
      squash = ($urandom_range(0, 11) == 0);
      if (squash) ld_req = 0;
   endtask

   int g[4];
   int ng;
   int nst;
   bit prev_busy;
   bit done;
   int exp_g[4];

   initial begin
      checks = 0; errors = 0;
      pend_valid = 0; pend_tag = '0; pend_cnt = 0;
      clear_inputs();
      rst_n = 0;
      model_reset();
      step();
      step();
      // Reset values
      check("rst_cmd", 32'(cmd), 32'(C_NONE));
      check("rst_addr", paddr, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ld_data", ld_data, 32'h0);
      rst_n = 1;
      step();

      // Single load: tag 3 accepted on first REQ cycle, data five cycles on.
      ld_req = 1; ld_addr = 32'h100; ld_size = 2'd2;
      step();
      check("ld1_cmd", 32'(cmd), 32'(C_LOAD));
      check("ld1_addr", paddr, 32'h100);
      check("ld1_size", 32'(psize), 32'd2);
      resp = 4'd3;
      step();
      resp = '0;
      check("ld1_wait_cmd", 32'(cmd), 32'(C_NONE));
      check("ld1_wait_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) step();
      dtag = 4'd3; ddata = 32'hDEADBEEF;
      step();
      dtag = '0; ddata = 32'h0;
      check("ld1_ack", 32'(ld_ack), 32'd1);
      check("ld1_data", ld_data, 32'hDEADBEEF);
      ld_req = 0;
      step();
      check("ld1_ack_once", 32'(ld_ack), 32'd0);
      check("ld1_idle", 32'(busy), 32'd0);

      // Squash in WAIT with tag 5 outstanding and a new load pending.
      ld_req = 1; ld_addr = 32'h300;
      step();
      resp = 4'd5;
      step();
      resp = '0;
      step();
      squash = 1; ld_addr = 32'h340;
      step();
      squash = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("sq_drain_busy", 32'(busy), 32'd1);
         check("sq_no_grant", 32'(cmd), 32'(C_NONE));
      end
      dtag = 4'd5; ddata = 32'hBAD0BAD0;
      step();
      dtag = '0;
      check("sq_no_ack", 32'(ld_ack), 32'd0);
      check("sq_ld_data_kept", ld_data, 32'hDEADBEEF);
      check("sq_idle", 32'(busy), 32'd0);
      step();
      check("sq_new_grant", 32'(cmd), 32'(C_LOAD));
      check("sq_new_addr", paddr, 32'h340);
      squash = 1; ld_req = 0;
      #1;
      check("sq_req_drop", 32'(cmd), 32'(C_NONE));
      step();
      squash = 0;
      check("sq_req_idle", 32'(busy), 32'd0);

      // Stray tag 7 while waiting for tag 4.
      ld_req = 1; ld_addr = 32'h440; ld_size = 2'd1;
      step();
      resp = 4'd4;
      step();
      resp = '0; dtag = 4'd7; ddata = 32'h77777777;
      step();
      dtag = '0;
      check("stray_no_ack", 32'(ld_ack), 32'd0);
      check("stray_busy", 32'(busy), 32'd1);
      dtag = 4'd4; ddata = 32'h44444444;
      step();
      dtag = '0;
      check("stray_ack", 32'(ld_ack), 32'd1);
      check("stray_data", ld_data, 32'h44444444);
      ld_req = 0;
      step();

      // Store rejected three times, accepted with tag 2.
      st_req = 1; st_addr = 32'h200; st_data = 32'h12345678; st_size = 2'd2;
      nst = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (cmd == C_STORE) nst++;
         check("st_addr_stable", paddr, 32'h200);
         check("st_data_stable", pdata, 32'h12345678);
         resp = (i == 3) ? 4'd2 : 4'd0;
      end
      step();
      resp = '0;
      check("st_cmd_cycles", 32'(nst), 32'd4);
      check("st_ack", 32'(st_ack), 32'd1);
      st_req = 0;
      step();
      check("st_ack_once", 32'(st_ack), 32'd0);
      check("st_idle", 32'(busy), 32'd0);

      // Reset while in WAIT, then the tag returns.
      ld_req = 1; ld_addr = 32'h900;
      step();
      resp = 4'd9;
      step();
      resp = '0;
      step();
      check("rw_busy", 32'(busy), 32'd1);
      rst_n = 0; ld_req = 0;
      #1;
      check("rw_async_busy", 32'(busy), 32'd0);
      step();
      rst_n = 1; dtag = 4'd9; ddata = 32'h99999999;
      step();
      dtag = '0;
      check("rw_no_ack", 32'(ld_ack), 32'd0);
      check("rw_idle", 32'(busy), 32'd0);
      check("rw_ld_data", ld_data, 32'h0);
      check("rw_addr", paddr, 32'h0);
      check("rw_cmd", 32'(cmd), 32'(C_NONE));
      step();

      // Both requesters held for four transactions, from a fresh reset.
      rst_n = 0;
      step();
      rst_n = 1;
      pend_valid = 0;
      ld_req = 1; ld_addr = 32'h400; ld_size = 2'd2;
      st_req = 1; st_addr = 32'h500; st_data = 32'h55AA55AA; st_size = 2'd2;
      ng = 0; prev_busy = 0; done = 0;
      for (int i = 0; i < 4; i++) g[i] = 0;
      for (int k = 0; k < 400 && !done; k++) begin
         step();
         if (busy && !prev_busy && ng < 4) begin
            g[ng] = int'(cmd);
            ng++;
         end
         prev_busy = busy;
         mem_drive();
         if (ng == 4 && (ld_ack || st_ack)) begin
            ld_req = 0; st_req = 0; done = 1;
         end
      end
`ifdef MEM_ARB_RR_EN
      exp_g = '{1, 2, 1, 2};
`else
      exp_g = '{1, 1, 1, 1};
`endif
      check("arb_grants", 32'(ng), 32'd4);
      for (int i = 0; i < 4; i++) check("arb_order", 32'(g[i]), 32'(exp_g[i]));
      step();
      check("arb_idle", 32'(busy), 32'd0);

      // Randomized traffic.
      clear_inputs();
      pend_valid = 0;
      for (int k = 0; k < 3000; k++) begin
         step();
         mem_drive();
         fu_drive();
      end
      ld_req = 0; st_req = 0; squash = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         mem_drive();
         if (!busy && !pend_valid) break;
      end
      check("final_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
